// File: rtl/izh_burst_scheduler.sv
// Burst scheduler: captures Izhikevich spike events, emits first spike at once and
// replays remaining burst spikes on time_ref ticks through an output AER FIFO.
module izh_burst_scheduler #(
  parameter int N_ADDR     = 8,
  parameter int SLOTS      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              neur_event_valid,
  input  logic [N_ADDR-1:0] neur_addr,
  input  logic [6:0]        neur_event,
  input  logic              time_ref,
  output logic              sched_ready,
  output logic              burst_end,
  output logic [N_ADDR-1:0] burst_end_addr,
  output logic              spk_out_valid,
  output logic [N_ADDR-1:0] spk_out_addr,
  input  logic              spk_out_ready,
  output logic              ovfl_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [N_ADDR-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              slot_act [SLOTS];
  logic              slot_due [SLOTS];
  logic [N_ADDR-1:0] slot_addr [SLOTS];
  logic [2:0]        slot_rem [SLOTS];
  logic [2:0]        slot_isi [SLOTS];
  logic [2:0]        slot_cnt [SLOTS];

  logic              capture, accept, drain, push, pop, full;
  logic              free_found, due_found;
  logic [SW-1:0]     free_idx, due_idx;
  logic [2:0]        extra, isi_in;
  logic [N_ADDR-1:0] push_data;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    due_found  = 1'b0;
    due_idx    = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!free_found && !slot_act[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
      if (!due_found && slot_act[i] && slot_due[i]) begin
        due_found = 1'b1;
        due_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    full        = (count == CW'(FIFO_DEPTH));
    sched_ready = !full && free_found;
    capture     = neur_event_valid && neur_event[6];
    accept      = capture && sched_ready;
    extra       = neur_event[5:3];
    isi_in      = (neur_event[2:0] == 3'd0) ? 3'd1 : neur_event[2:0];
    // Any capture, even a dropped one, blocks drain so burst_end never collides.
    drain       = !capture && due_found && !full;
    push        = accept || drain;
    push_data   = accept ? neur_addr : slot_addr[due_idx];
    pop         = (count != '0) && spk_out_ready;
  end

  assign spk_out_valid = (count != '0);
  assign spk_out_addr  = fifo_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      burst_end      <= 1'b0;
      burst_end_addr <= '0;
      ovfl_err       <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_act[i]  <= 1'b0;
        slot_due[i]  <= 1'b0;
        slot_addr[i] <= '0;
        slot_rem[i]  <= '0;
        slot_isi[i]  <= '0;
        slot_cnt[i]  <= '0;
      end
    end else begin
      burst_end <= 1'b0;

      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (time_ref && slot_act[i] && !slot_due[i]) begin
          if (slot_cnt[i] == 3'd1) slot_due[i] <= 1'b1;
          else                     slot_cnt[i] <= slot_cnt[i] - 3'd1;
        end
      end

      if (capture) begin
        if (!sched_ready) begin
          ovfl_err       <= 1'b1;
          burst_end      <= 1'b1;
          burst_end_addr <= neur_addr;
        end else if (extra == 3'd0) begin
          burst_end      <= 1'b1;
          burst_end_addr <= neur_addr;
        end else begin
          slot_act[free_idx]  <= 1'b1;
          slot_due[free_idx]  <= 1'b0;
          slot_addr[free_idx] <= neur_addr;
          slot_rem[free_idx]  <= extra;
          slot_isi[free_idx]  <= isi_in;
          slot_cnt[free_idx]  <= isi_in;
        end
      end

      if (drain) begin
        slot_rem[due_idx] <= slot_rem[due_idx] - 3'd1;
        slot_cnt[due_idx] <= slot_isi[due_idx];
        slot_due[due_idx] <= 1'b0;
        if (slot_rem[due_idx] == 3'd1) begin
          slot_act[due_idx] <= 1'b0;
          burst_end         <= 1'b1;
          burst_end_addr    <= slot_addr[due_idx];
        end
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_izh_burst_scheduler.sv
// Directed self-checking bench for izh_burst_scheduler with hand-computed expectations.
module tb_izh_burst_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       neur_event_valid = 1'b0;
  logic [7:0] neur_addr = '0;
  logic [6:0] neur_event = '0;
  logic       time_ref = 1'b0;
  logic       sched_ready;
  logic       burst_end;
  logic [7:0] burst_end_addr;
  logic       spk_out_valid;
  logic [7:0] spk_out_addr;
  logic       spk_out_ready = 1'b0;
  logic       ovfl_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_bad;

  izh_burst_scheduler #(.N_ADDR(8), .SLOTS(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .neur_event_valid(neur_event_valid), .neur_addr(neur_addr), .neur_event(neur_event),
    .time_ref(time_ref), .sched_ready(sched_ready),
    .burst_end(burst_end), .burst_end_addr(burst_end_addr),
    .spk_out_valid(spk_out_valid), .spk_out_addr(spk_out_addr),
    .spk_out_ready(spk_out_ready), .ovfl_err(ovfl_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [7:0] a, input logic [6:0] ev);
    neur_event_valid = 1'b1;
    neur_addr        = a;
    neur_event       = ev;
    cyc();
    neur_event_valid = 1'b0;
    neur_event       = '0;
  endtask

  task automatic tick();
    time_ref = 1'b1;
    cyc();
    time_ref = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    RST = 1'b0;
    check_eq("rst_valid", 32'(spk_out_valid), 32'd0);
    check_eq("rst_bend", 32'(burst_end), 32'd0);
    check_eq("rst_bend_addr", 32'(burst_end_addr), 32'd0);
    check_eq("rst_ovfl", 32'(ovfl_err), 32'd0);
    check_eq("rst_ready", 32'(sched_ready), 32'd1);

    // Event without spike flag is ignored
    capture(8'h77, 7'b0_011_010);
    check_eq("noflag_valid", 32'(spk_out_valid), 32'd0);
    check_eq("noflag_bend", 32'(burst_end), 32'd0);

    // Single spike
    capture(8'h12, 7'b1_000_000);
    check_eq("single_valid", 32'(spk_out_valid), 32'd1);
    check_eq("single_addr", 32'(spk_out_addr), 32'h12);
    check_eq("single_bend", 32'(burst_end), 32'd1);
    check_eq("single_bend_addr", 32'(burst_end_addr), 32'h12);
    spk_out_ready = 1'b1;
    cyc();
    check_eq("single_bend_pulse", 32'(burst_end), 32'd0);
    check_eq("single_popped", 32'(spk_out_valid), 32'd0);

    // Burst of 3, ISI=2: spikes at capture+1, after tick 2 and tick 4
    capture(8'h05, 7'b1_010_010);
    check_eq("b3_first_valid", 32'(spk_out_valid), 32'd1);
    check_eq("b3_first_addr", 32'(spk_out_addr), 32'h05);
    check_eq("b3_first_bend", 32'(burst_end), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      repeat (9) cyc();
      tick();
      check_eq($sformatf("b3_tick%0d_quiet", k), 32'(spk_out_valid), 32'd0);
      cyc();
      check_eq($sformatf("b3_tick%0d_valid", k), 32'(spk_out_valid), 32'(k == 2 || k == 4));
      if (k == 2 || k == 4)
        check_eq($sformatf("b3_tick%0d_addr", k), 32'(spk_out_addr), 32'h05);
      check_eq($sformatf("b3_tick%0d_bend", k), 32'(burst_end), 32'(k == 4));
      if (k == 4)
        check_eq("b3_bend_addr", 32'(burst_end_addr), 32'h05);
    end

    // ISI=0 treated as 1
    capture(8'h09, 7'b1_001_000);
    check_eq("isi0_first_addr", 32'(spk_out_addr), 32'h09);
    repeat (5) cyc();
    tick();
    check_eq("isi0_quiet", 32'(spk_out_valid), 32'd0);
    cyc();
    check_eq("isi0_valid", 32'(spk_out_valid), 32'd1);
    check_eq("isi0_addr", 32'(spk_out_addr), 32'h09);
    check_eq("isi0_bend", 32'(burst_end), 32'd1);
    check_eq("isi0_bend_addr", 32'(burst_end_addr), 32'h09);
    repeat (3) cyc();

    // Contention: 4 slots drain in index order; mid-drain capture delays by one cycle
    for (int i = 0; i < 4; i++) capture(8'(8'h20 + i), 7'b1_001_001);
    check_eq("cont_slots_full", 32'(sched_ready), 32'd0);
    repeat (3) cyc();
    tick();
    cyc();
    check_eq("cont_d0_addr", 32'(spk_out_addr), 32'h20);
    check_eq("cont_d0_bend", 32'(burst_end_addr), 32'h20);
    cyc();
    check_eq("cont_d1_addr", 32'(spk_out_addr), 32'h21);
    check_eq("cont_d1_bend", 32'(burst_end_addr), 32'h21);
    capture(8'h30, 7'b1_000_000);
    check_eq("cont_cap_addr", 32'(spk_out_addr), 32'h30);
    check_eq("cont_cap_bend", 32'(burst_end_addr), 32'h30);
    cyc();
    check_eq("cont_d2_addr", 32'(spk_out_addr), 32'h22);
    check_eq("cont_d2_bend", 32'(burst_end), 32'd1);
    cyc();
    check_eq("cont_d3_addr", 32'(spk_out_addr), 32'h23);
    check_eq("cont_d3_bend_addr", 32'(burst_end_addr), 32'h23);
    cyc();
    check_eq("cont_done", 32'(spk_out_valid), 32'd0);
    check_eq("cont_free", 32'(sched_ready), 32'd1);

    // Overflow with backpressure
    spk_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) capture(8'(8'h40 + i), 7'b1_000_000);
    check_eq("ovf_full_ready", 32'(sched_ready), 32'd0);
    check_eq("ovf_pre", 32'(ovfl_err), 32'd0);
    capture(8'h44, 7'b1_000_000);
    check_eq("ovf_set", 32'(ovfl_err), 32'd1);
    check_eq("ovf_bend", 32'(burst_end), 32'd1);
    check_eq("ovf_bend_addr", 32'(burst_end_addr), 32'h44);
    check_eq("ovf_head", 32'(spk_out_addr), 32'h40);
    spk_out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cyc();
      check_eq($sformatf("ovf_drain%0d", k), 32'(spk_out_addr), 32'(8'h40 + k));
    end
    cyc();
    check_eq("ovf_empty", 32'(spk_out_valid), 32'd0);
    check_eq("ovf_sticky", 32'(ovfl_err), 32'd1);

    // Reset mid-burst
    spk_out_ready = 1'b0;
    capture(8'h50, 7'b1_010_001);
    capture(8'h51, 7'b1_010_001);
    capture(8'h52, 7'b1_000_000);
    check_eq("rmb_valid_pre", 32'(spk_out_valid), 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check_eq("rmb_valid", 32'(spk_out_valid), 32'd0);
    check_eq("rmb_ready", 32'(sched_ready), 32'd1);
    check_eq("rmb_ovfl", 32'(ovfl_err), 32'd0);
    check_eq("rmb_bend", 32'(burst_end), 32'd0);
    spk_out_ready = 1'b1;
    seen_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (burst_end || spk_out_valid) seen_bad = 1'b1;
      repeat (5) begin
        cyc();
        if (burst_end || spk_out_valid) seen_bad = 1'b1;
      end
    end
    check_eq("rmb_silent", 32'(seen_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
